hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Iterative multiply/divide unit with the architectural HI/LO register pair, sitting in the EX stage beside the main ALU. It consumes the 5-bit ALU control code from the EX-stage control decode and executes the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations. Multiplies and divides run for multiple cycles, and `busy` stalls the pipeline while one is in flight. HI/LO read ports feed the MFHI/MFLO forwarding path.

## Interface
Parameters:
- `MULT_OP`, default 5'b00110: signed multiply code.
- `MULTU_OP`, default 5'b00111: unsigned multiply code.
- `DIV_OP`, default 5'b01000: signed divide code.
- `DIVU_OP`, default 5'b01001: unsigned divide code.
- `MTHI_OP`, default 5'b10010: move to HI code.
- `MTLO_OP`, default 5'b10011: move to LO code.

Ports:
- `clk`  in  1: single clock, all state on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: an EX-stage instruction is valid this cycle.
- `alu_ctrl_in`  in  5: ALU control code of the EX instruction.
- `op_a`  in  32: rs value; the dividend or multiplicand; the MTHI/MTLO source.
- `op_b`  in  32: rt value; the divisor or multiplier.
- `cancel`  in  1: pipeline flush; aborts the in-flight operation.
- `busy`  out  1: operation in flight; the pipeline must stall any HI/LO consumer or new mul/div.
- `done`  out  1: one-cycle pulse when HI/LO receive a mul/div result.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- States are IDLE, RUN and FIX. `busy = (state != IDLE)`.
- **Accept.** In IDLE with `start=1`, `cancel=0` and `alu_ctrl_in` a mul/div code:
  - latch the op kind and the sign info;
  - latch the operand magnitudes: two's-complement absolute values for MULT/DIV, raw values for the unsigned codes;
  - clear the 5-bit iteration counter and go to RUN.
- **MTHI/MTLO.** In IDLE with `start=1` and `cancel=0`:
  - `hi<=op_a` (MTHI) or `lo<=op_a` (MTLO) at the same edge;
  - state stays IDLE, no `busy`, no `done`.
- **Ignored starts.** Other codes, and any `start` while `busy=1`, are ignored with no state change.
- **RUN, multiply.** Radix-2 shift-add.
  - Each cycle, if multiplier bit 0 = 1, add the multiplicand into the upper half of the 64-bit accumulator.
  - Shift the accumulator and the multiplier right by 1.
- **RUN, divide.** Restoring division.
  - Each cycle, shift the {remainder, quotient} pair left by 1 and trial-subtract the divisor from the 33-bit remainder.
  - If the result is non-negative, keep it and set quotient bit 0 = 1; otherwise restore.
- **RUN length.** RUN lasts exactly 32 cycles: the counter runs 0..31, and RUN→FIX is taken on the cycle with counter=31.
- **FIX.** One cycle; writes HI/LO and pulses `done`, then returns to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ. {hi,lo} ← product.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend. lo ← quotient, hi ← remainder.
  - Unsigned ops: no sign correction.
- **Divide by zero.** Divisor = 0, any signedness: lo = 32'hFFFFFFFF, hi = op_a as originally presented (unsigned remainder = dividend).
- **Signed overflow.** 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (natural wrap).
- **cancel.** `cancel=1` in RUN or FIX returns to IDLE next edge. HI/LO are unchanged and `done` stays 0. `cancel` wins over a simultaneous `start`.
- **rst.** Overrides everything, including mid-operation.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0, datapath registers 0.
- **Mul/div accept.** Accept at edge E0.
  - `busy`=1 from after E0 through E33: 32 RUN cycles plus 1 FIX cycle, i.e. 33 cycles high.
  - FIX writes HI/LO at edge E33; the new `hi`/`lo` are visible and `busy`=0 after E33.
  - `done` is registered: high for exactly the cycle after E33.
- **MTHI/MTLO:** 1-cycle latency; the register is updated after the accepting edge.
- **Back-to-back:** a new mul/div may be accepted on the first cycle `busy`=0, i.e. at edge E34.
- **Output timing:** `busy`, `hi` and `lo` are register outputs with no combinational path from inputs.

## Test plan
- **MULTU.** `op_a`=`op_b`=0xFFFFFFFF -> `busy` high 33 cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` single pulse.
- **MULT.** `op_a`=-3 (0xFFFFFFFD), `op_b`=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then MULT 0x80000000×0x80000000 -> `hi`=0x40000000, `lo`=0.
- **Signed divides.**
  - DIV -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 7/-2 -> `lo`=0xFFFFFFFD, `hi`=1.
  - DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- **Unsigned divides.** DIVU 100/7 -> `lo`=14, `hi`=2. DIVU 7/0 and DIV -7/0 -> `lo`=0xFFFFFFFF, `hi`=op_a.
- **Busy and cancel.**
  - MTHI 0x1234 -> `hi`=0x1234 next cycle, `busy` stays 0.
  - MTLO during a busy divide -> ignored.
  - `cancel` at RUN cycle 10 -> IDLE next cycle, HI/LO keep prior values, no `done`.
  - `start`+`cancel` together in IDLE -> nothing accepted.
- **Reset.** `rst` asserted mid-multiply -> next cycle `busy`=0, `hi`=`lo`=0. Then a fresh MULTU 6×7 -> `lo`=42 after 33 busy cycles.

Source files
------------

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit owning the HI/LO register pair.
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring division)
// in 32 RUN cycles plus one FIX cycle for sign correction and HI/LO write.
// MTHI/MTLO write HI/LO directly in one cycle.
//
// Ports:
//   clk         - clock, all state on the rising edge
//   rst         - synchronous active-high reset
//   start       - EX-stage instruction valid
//   alu_ctrl_in - 5-bit ALU control code
//   op_a        - rs: multiplicand / dividend / MTHI-MTLO source
//   op_b        - rt: multiplier / divisor
//   cancel      - pipeline flush, aborts an in-flight operation
//   busy        - operation in flight
//   done        - one-cycle pulse when HI/LO receive a mul/div result
//   hi, lo      - architectural HI/LO registers
module hilo_muldiv #(
    parameter logic [4:0] MULT_OP  = 5'b00110,
    parameter logic [4:0] MULTU_OP = 5'b00111,
    parameter logic [4:0] DIV_OP   = 5'b01000,
    parameter logic [4:0] DIVU_OP  = 5'b01001,
    parameter logic [4:0] MTHI_OP  = 5'b10010,
    parameter logic [4:0] MTLO_OP  = 5'b10011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  alu_ctrl_in,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // operand signs differ
    logic        neg_rem_q, neg_rem_d;   // dividend was negative
    logic        div0_q, div0_d;
    logic [31:0] opa_q, opa_d;           // op_a as presented, for divide by zero
    logic [31:0] mcand_q, mcand_d;       // multiplicand or divisor magnitude
    logic [31:0] work_q, work_d;         // multiplier/low product, or dividend/quotient
    logic [31:0] acc_q, acc_d;           // upper product half, or remainder
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        code_mul, code_div, code_signed;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic [63:0] product, product_neg;

    always_comb begin
        code_mul    = (alu_ctrl_in == MULT_OP) || (alu_ctrl_in == MULTU_OP);
        code_div    = (alu_ctrl_in == DIV_OP) || (alu_ctrl_in == DIVU_OP);
        code_signed = (alu_ctrl_in == MULT_OP) || (alu_ctrl_in == DIV_OP);
        abs_a = (code_signed && op_a[31]) ? 32'd0 - op_a : op_a;
        abs_b = (code_signed && op_b[31]) ? 32'd0 - op_b : op_b;

        mul_sum     = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : 33'd0);
        // Remainder < divisor, so the shifted value always fits in 33 bits and
        // bit 32 of the difference is a reliable borrow.
        div_shift   = {acc_q, work_q[31]};
        div_diff    = div_shift - {1'b0, mcand_q};
        product     = {acc_q, work_q};
        product_neg = 64'd0 - product;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opa_d     = opa_q;
        mcand_d   = mcand_q;
        work_d    = work_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !cancel) begin
                    if (code_mul || code_div) begin
                        state_d   = StRun;
                        cnt_d     = 5'd0;
                        is_div_d  = code_div;
                        neg_res_d = code_signed && (op_a[31] ^ op_b[31]);
                        neg_rem_d = code_signed && op_a[31];
                        div0_d    = (op_b == 32'd0);
                        opa_d     = op_a;
                        acc_d     = 32'd0;
                        mcand_d   = code_div ? abs_b : abs_a;
                        work_d    = code_div ? abs_a : abs_b;
                    end else if (alu_ctrl_in == MTHI_OP) begin
                        hi_d = op_a;
                    end else if (alu_ctrl_in == MTLO_OP) begin
                        lo_d = op_a;
                    end
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[32]) begin
                            acc_d  = div_diff[31:0];
                            work_d = {work_q[30:0], 1'b1};
                        end else begin
                            acc_d  = div_shift[31:0];
                            work_d = {work_q[30:0], 1'b0};
                        end
                    end else begin
                        acc_d  = mul_sum[32:1];
                        work_d = {mul_sum[0], work_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = neg_res_q ? product_neg : product;
                    end else if (div0_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = opa_q;
                    end else begin
                        lo_d = neg_res_q ? 32'd0 - work_q : work_q;
                        hi_d = neg_rem_q ? 32'd0 - acc_q : acc_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opa_q     <= 32'd0;
            mcand_q   <= 32'd0;
            work_q    <= 32'd0;
            acc_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opa_q     <= opa_d;
            mcand_q   <= mcand_d;
            work_q    <= work_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_hilo_muldiv;

    localparam logic [4:0] C_MULT  = 5'b00110;
    localparam logic [4:0] C_MULTU = 5'b00111;
    localparam logic [4:0] C_DIV   = 5'b01000;
    localparam logic [4:0] C_DIVU  = 5'b01001;
    localparam logic [4:0] C_MTHI  = 5'b10010;
    localparam logic [4:0] C_MTLO  = 5'b10011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  alu_ctrl_in = 5'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    hilo_muldiv dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_ctrl_in (alu_ctrl_in),
        .op_a        (op_a),
        .op_b        (op_b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain arithmetic on the architectural definition.
    function automatic void ref_model(input logic [4:0] code, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] rh,
                                      output logic [31:0] rl);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        rh = 32'd0;
        rl = 32'd0;
        sa = a;
        sb = b;
        if (code == C_MULTU) begin
            up = {32'd0, a} * {32'd0, b};
            {rh, rl} = up;
        end else if (code == C_MULT) begin
            sp = longint'(sa) * longint'(sb);
            {rh, rl} = sp;
        end else if (b == 32'd0) begin
            rl = 32'hFFFF_FFFF;
            rh = a;
        end else if (code == C_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                rl = 32'h8000_0000;
                rh = 32'd0;
            end else begin
                rl = sa / sb;
                rh = sa % sb;
            end
        end else begin
            rl = a / b;
            rh = a % b;
        end
    endfunction

    // Issue one mul/div starting now (1 time unit after an edge) and wait for
    // busy to drop; reports busy length, done at that point, and HI/LO.
    task automatic do_muldiv(input logic [4:0] code, input logic [31:0] a,
                             input logic [31:0] b, output int nbusy, output logic d_end,
                             output logic [31:0] h, output logic [31:0] l);
        start = 1'b1;
        alu_ctrl_in = code;
        op_a = a;
        op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 40) begin
            @(posedge clk); #1;
            nbusy++;
        end
        d_end = done;
        h = hi;
        l = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h exp 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h exp 0", lo); end
        rst = 1'b0;
    endtask

    task automatic test_multu();
        int n; logic d; logic [31:0] h, l;
        do_muldiv(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, d, h, l);
        checks++; if (n != 33) begin errors++; $display("FAIL multu_busy_len: got %0d exp 33", n); end
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL multu_done: got %b exp 1", d); end
        checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h exp fffffffe", h); end
        checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h exp 00000001", l); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b exp 0", done); end
    endtask

    task automatic test_mult();
        int n; logic d; logic [31:0] h, l;
        do_muldiv(C_MULT, 32'hFFFF_FFFD, 32'd5, n, d, h, l);
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h exp ffffffff", h); end
        checks++; if (l !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg_lo: got %h exp fffffff1", l); end
        do_muldiv(C_MULT, 32'h8000_0000, 32'h8000_0000, n, d, h, l);
        checks++; if (h !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi: got %h exp 40000000", h); end
        checks++; if (l !== 32'd0) begin errors++; $display("FAIL mult_min_lo: got %h exp 0", l); end
    endtask

    task automatic test_div_signed();
        int n; logic d; logic [31:0] h, l;
        do_muldiv(C_DIV, 32'hFFFF_FFF9, 32'd2, n, d, h, l);
        checks++; if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_m7_2: got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", h, l); end
        do_muldiv(C_DIV, 32'd7, 32'hFFFF_FFFE, n, d, h, l);
        checks++; if (l !== 32'hFFFF_FFFD || h !== 32'd1) begin
            errors++; $display("FAIL div_7_m2: got hi=%h lo=%h exp hi=00000001 lo=fffffffd", h, l); end
        do_muldiv(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, d, h, l);
        checks++; if (l !== 32'h8000_0000 || h !== 32'd0) begin
            errors++; $display("FAIL div_overflow: got hi=%h lo=%h exp hi=0 lo=80000000", h, l); end
    endtask

    task automatic test_div_unsigned();
        int n; logic d; logic [31:0] h, l;
        do_muldiv(C_DIVU, 32'd100, 32'd7, n, d, h, l);
        checks++; if (l !== 32'd14 || h !== 32'd2) begin
            errors++; $display("FAIL divu_100_7: got hi=%h lo=%h exp hi=2 lo=e", h, l); end
        do_muldiv(C_DIVU, 32'd7, 32'd0, n, d, h, l);
        checks++; if (l !== 32'hFFFF_FFFF || h !== 32'd7) begin
            errors++; $display("FAIL divu_by0: got hi=%h lo=%h exp hi=7 lo=ffffffff", h, l); end
        do_muldiv(C_DIV, 32'hFFFF_FFF9, 32'd0, n, d, h, l);
        checks++; if (l !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFF9) begin
            errors++; $display("FAIL div_by0: got hi=%h lo=%h exp hi=fffffff9 lo=ffffffff", h, l); end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; alu_ctrl_in = C_MTHI; op_a = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h exp 1234", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mthi_busy: got busy=%b done=%b exp 0 0", busy, done); end
        start = 1'b1; alu_ctrl_in = C_MTLO; op_a = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (lo !== 32'h5678 || hi !== 32'h1234) begin
            errors++; $display("FAIL mtlo: got hi=%h lo=%h exp hi=1234 lo=5678", hi, lo); end
    endtask

    task automatic test_mtlo_busy();
        int n;
        start = 1'b1; alu_ctrl_in = C_DIVU; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; alu_ctrl_in = C_MTLO; op_a = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo_busy_now: got %h exp 5678", lo); end
        n = 0;
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL mtlo_busy_result: got hi=%h lo=%h exp hi=2 lo=e", hi, lo); end
    endtask

    task automatic test_cancel();
        int n, dones; logic d; logic [31:0] h, l;
        do_muldiv(C_MULTU, 32'd6, 32'd7, n, d, h, l);
        start = 1'b1; alu_ctrl_in = C_DIV; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b exp 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin
            errors++; $display("FAIL cancel_hilo: got hi=%h lo=%h exp hi=0 lo=2a", hi, lo); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL cancel_done: got %0d pulses exp 0", dones); end
    endtask

    task automatic test_start_cancel();
        start = 1'b1; cancel = 1'b1; alu_ctrl_in = C_MULTU; op_a = 32'd3; op_b = 32'd3;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_cancel_busy: got %b exp 0", busy); end
        alu_ctrl_in = C_MTHI; op_a = 32'h9999;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL start_cancel_mthi: got %h exp 0", hi); end
    endtask

    task automatic test_reset_mid();
        int n; logic d; logic [31:0] h, l;
        do_muldiv(C_MULTU, 32'd3, 32'd5, n, d, h, l);
        start = 1'b1; alu_ctrl_in = C_MULTU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busy: got busy=%b done=%b exp 0 0", busy, done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_mid_hilo: got hi=%h lo=%h exp 0 0", hi, lo); end
        do_muldiv(C_MULTU, 32'd6, 32'd7, n, d, h, l);
        checks++; if (n != 33 || l !== 32'd42 || h !== 32'd0) begin
            errors++; $display("FAIL reset_mid_multu: got busy=%0d hi=%h lo=%h exp 33 0 2a", n, h, l); end
    endtask

    task automatic test_back_to_back();
        int n; logic d; logic [31:0] h, l, eh, el;
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
        do_muldiv(C_MULT, a1, b1, n, d, h, l);
        ref_model(C_MULT, a1, b1, eh, el);
        checks++; if (h !== eh || l !== el) begin
            errors++; $display("FAIL b2b_first: got hi=%h lo=%h exp hi=%h lo=%h", h, l, eh, el); end
        // Issued on the first non-busy cycle, so it is accepted at E34.
        do_muldiv(C_DIVU, a2, b2, n, d, h, l);
        ref_model(C_DIVU, a2, b2, eh, el);
        checks++; if (n != 33 || d !== 1'b1 || h !== eh || l !== el) begin
            errors++; $display("FAIL b2b_second: got busy=%0d done=%b hi=%h lo=%h exp 33 1 %h %h",
                               n, d, h, l, eh, el); end
    endtask

    task automatic test_random();
        int n; logic d; logic [31:0] h, l, eh, el, a, b;
        logic [4:0] code;
        logic [4:0] codes [4];
        codes[0] = C_MULT; codes[1] = C_MULTU; codes[2] = C_DIV; codes[3] = C_DIVU;
        for (int i = 0; i < 16; i++) begin
            code = codes[$urandom_range(0, 3)];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            ref_model(code, a, b, eh, el);
            do_muldiv(code, a, b, n, d, h, l);
            checks++; if (n != 33 || d !== 1'b1 || h !== eh || l !== el) begin
                errors++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got busy=%0d done=%b hi=%h lo=%h exp 33 1 %h %h",
                         i, code, a, b, n, d, h, l, eh, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div_signed();
        test_div_unsigned();
        test_mthi_mtlo();
        test_mtlo_busy();
        test_cancel();
        test_start_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
